// File: rtl/gate_ctrl_pkg.sv
// Shared definitions for the gate enable controller.
// Contents:
//   gate_state_e  - controller state encoding, also driven out on state_o
//   FLT_EXT/FLT_ST - bit positions inside the sticky fault code
//   STATE_W/CODE_W - widths of the state and fault-code outputs
package gate_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int CODE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } gate_state_e;

  localparam int FLT_EXT = 0;
  localparam int FLT_ST  = 1;

endpackage

// File: rtl/pwm_shoot_detect.sv
// Shoot-through detector for one upper/lower gate pair.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   hi_i, lo_i    - upper and lower gate drive of the same phase leg
//   st_fault_o    - one-cycle pulse once the pair has been both-high for
//                   ST_FILTER consecutive cycles
module pwm_shoot_detect #(
  parameter int ST_FILTER = 2,
  parameter int CNT_W     = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hi_i,
  input  logic lo_i,
  output logic st_fault_o
);

  localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(ST_FILTER);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(ST_FILTER - 1);

  logic             both_d;
  logic [CNT_W-1:0] cnt_q;
  logic             st_fault_q;

  assign both_d = hi_i & lo_i;

  // The counter saturates at ST_FILTER, so the "about to reach" condition is
  // true only once per both-high episode and the flag is a single pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      st_fault_q <= 1'b0;
    end else begin
      st_fault_q <= both_d && (cnt_q == FILT_LAST);
      if (!both_d) begin
        cnt_q <= '0;
      end else if (cnt_q != FILT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign st_fault_o = st_fault_q;

endmodule

// File: rtl/gate_enable_ctrl.sv
// Gate enable controller: sequences arming of the inverter gate outputs,
// watches the PWM pairs U/X, V/Y, W/Z for shoot-through and latches
// external/shoot-through faults until a qualified clear.
// Ports:
//   clk_i, rst_ni     - clock and asynchronous active-low reset
//   arm_req_i         - level request to enable outputs
//   disarm_i          - level disable request, overrides arm_req_i
//   fault_n_i         - external driver fault, active-low, asynchronous
//   fault_clr_i       - fault clear request, sampled every cycle
//   u_i..w_i, x_i..z_i - upper / lower PWM gate signals
//   en_output_o       - registered gate enable
//   state_o           - 0 IDLE, 1 ARMING, 2 RUN, 3 FAULT
//   fault_code_o      - sticky, bit0 external, bit1 shoot-through
//   ready_o           - idle with no external fault present
module gate_enable_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int ARM_DELAY  = 1000,
  parameter int ST_FILTER  = 2,
  parameter int FAULT_HOLD = 100,
  parameter int CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               arm_req_i,
  input  logic               disarm_i,
  input  logic               fault_n_i,
  input  logic               fault_clr_i,
  input  logic               u_i,
  input  logic               v_i,
  input  logic               w_i,
  input  logic               x_i,
  input  logic               y_i,
  input  logic               z_i,
  output logic               en_output_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CODE_W-1:0]  fault_code_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(FAULT_HOLD);

  // Synchronizer for the asynchronous fault input; idles at the inactive
  // level so reset does not fabricate an external fault.
  logic fsync1_q, fsync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsync1_q <= 1'b1;
      fsync2_q <= 1'b1;
    end else begin
      fsync1_q <= fault_n_i;
      fsync2_q <= fsync1_q;
    end
  end

  logic       ext_fault_d;
  logic [2:0] st_fault_d;
  logic       both_hi_d;

  assign ext_fault_d = ~fsync2_q;
  assign both_hi_d   = (u_i & x_i) | (v_i & y_i) | (w_i & z_i);

  pwm_shoot_detect #(.ST_FILTER(ST_FILTER), .CNT_W(CNT_W)) u_det_ux (
    .clk_i(clk_i), .rst_ni(rst_ni), .hi_i(u_i), .lo_i(x_i), .st_fault_o(st_fault_d[0])
  );
  pwm_shoot_detect #(.ST_FILTER(ST_FILTER), .CNT_W(CNT_W)) u_det_vy (
    .clk_i(clk_i), .rst_ni(rst_ni), .hi_i(v_i), .lo_i(y_i), .st_fault_o(st_fault_d[1])
  );
  pwm_shoot_detect #(.ST_FILTER(ST_FILTER), .CNT_W(CNT_W)) u_det_wz (
    .clk_i(clk_i), .rst_ni(rst_ni), .hi_i(w_i), .lo_i(z_i), .st_fault_o(st_fault_d[2])
  );

  gate_state_e       state_q;
  logic              en_q;
  logic [CODE_W-1:0] code_q;
  logic              ready_q;
  logic [CNT_W-1:0]  arm_cnt_q;
  logic [CNT_W-1:0]  hold_q;

  logic              fault_any_d;
  logic [CODE_W-1:0] code_set_d;
  logic              arm_ok_d;
  logic              clr_ok_d;

  always_comb begin
    code_set_d          = '0;
    code_set_d[FLT_EXT] = ext_fault_d;
    code_set_d[FLT_ST]  = |st_fault_d;
  end

  assign fault_any_d = |code_set_d;
  assign arm_ok_d    = arm_req_i & ~disarm_i;
  // A clear is honoured only once the hold time has fully elapsed and the
  // plant is quiet; arm_req_i must be low so the bridge never re-arms itself.
  assign clr_ok_d    = (hold_q == HOLD_MAX) & fault_clr_i & ~ext_fault_d &
                       ~both_hi_d & ~arm_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      code_q    <= '0;
      ready_q   <= 1'b0;
      arm_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      ready_q <= (state_q == ST_IDLE) && !ext_fault_d;
      // Fault detection wins over every other transition in every state.
      if (fault_any_d) begin
        state_q <= ST_FAULT;
        en_q    <= 1'b0;
        code_q  <= code_q | code_set_d;
        hold_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            en_q <= 1'b0;
            if (arm_ok_d) begin
              state_q   <= ST_ARMING;
              arm_cnt_q <= '0;
            end
          end
          ST_ARMING: begin
            if (!arm_ok_d) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
            end else if (arm_cnt_q == ARM_LAST) begin
              state_q <= ST_RUN;
              en_q    <= 1'b1;
            end else begin
              arm_cnt_q <= arm_cnt_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (!arm_ok_d) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
            end
          end
          ST_FAULT: begin
            en_q <= 1'b0;
            if (hold_q != HOLD_MAX) begin
              hold_q <= hold_q + CNT_W'(1);
            end
            if (clr_ok_d) begin
              state_q <= ST_IDLE;
              code_q  <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_output_o  = en_q;
  assign state_o      = state_q;
  assign fault_code_o = code_q;
  assign ready_o      = ready_q;

endmodule

// File: tb/tb_gate_enable_ctrl.sv
module tb_gate_enable_ctrl;

  localparam int ARM_DELAY  = 4;
  localparam int ST_FILTER  = 2;
  localparam int FAULT_HOLD = 8;
  localparam int CNT_W      = 16;

  logic       clk;
  logic       rst_n;
  logic       arm, disarm, fault_n, clr;
  logic       u, v, w, x, y, z;
  logic       en;
  logic [1:0] state;
  logic [1:0] code;
  logic       ready;

  int checks;
  int errors;

  gate_enable_ctrl #(
    .ARM_DELAY(ARM_DELAY), .ST_FILTER(ST_FILTER),
    .FAULT_HOLD(FAULT_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .arm_req_i(arm), .disarm_i(disarm),
    .fault_n_i(fault_n), .fault_clr_i(clr),
    .u_i(u), .v_i(v), .w_i(w), .x_i(x), .y_i(y), .z_i(z),
    .en_output_o(en), .state_o(state), .fault_code_o(code), .ready_o(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 arming, 2 run, 3 fault. Timing is tracked as edge
  // numbers (when arming began, when the last fault was seen) rather than
  // as counters.
  int m_mode, m_code, m_ready, m_en;
  int m_edge, m_arm_edge, m_fault_edge;
  int m_run[3];
  bit m_fq[$];

  initial begin
    m_mode = 0; m_code = 0; m_ready = 0; m_en = 0; m_edge = 0;
    m_arm_edge = 0; m_fault_edge = 0;
    foreach (m_run[i]) m_run[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_code = 0; m_ready = 0; m_en = 0; m_edge = 0;
        foreach (m_run[i]) m_run[i] = 0;
        m_fq.delete();
      end else begin
        bit ext, st, both_now, ok;
        bit hi[3], lo[3];
        hi[0] = u; hi[1] = v; hi[2] = w;
        lo[0] = x; lo[1] = y; lo[2] = z;
        // the fault input takes two edges to reach the decision logic
        ext = (m_fq.size() >= 2) ? !m_fq[m_fq.size()-2] : 1'b0;
        st = 1'b0;
        both_now = 1'b0;
        for (int p = 0; p < 3; p++) begin
          if (m_run[p] == ST_FILTER) st = 1'b1;
          if (hi[p] && lo[p]) both_now = 1'b1;
        end
        ok = arm && !disarm;
        m_ready = (m_mode == 0 && !ext) ? 1 : 0;
        if (ext || st) begin
          m_code = m_code | (st ? 2 : 0) | (ext ? 1 : 0);
          m_mode = 3;
          m_fault_edge = m_edge;
        end else begin
          case (m_mode)
            0: if (ok) begin m_mode = 1; m_arm_edge = m_edge; end
            1: if (!ok) m_mode = 0;
               else if (m_edge - m_arm_edge == ARM_DELAY) m_mode = 2;
            2: if (!ok) m_mode = 0;
            default:
              if ((m_edge - m_fault_edge > FAULT_HOLD) && clr && !both_now && !arm) begin
                m_mode = 0;
                m_code = 0;
              end
          endcase
        end
        m_en = (m_mode == 2) ? 1 : 0;
        for (int p = 0; p < 3; p++) m_run[p] = (hi[p] && lo[p]) ? m_run[p] + 1 : 0;
        m_fq.push_back(fault_n);
        if (m_fq.size() > 2) void'(m_fq.pop_front());
        m_edge++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model_state", int'(state), m_mode);
        chk("model_en", int'(en), m_en);
        chk("model_code", int'(code), m_code);
        chk("model_ready", int'(ready), m_ready);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; arm = 0; disarm = 0; fault_n = 1; clr = 0;
    u = 0; v = 0; w = 0; x = 0; y = 0; z = 0;
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_ready", int'(ready), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_rst", int'(ready), 1);

    // nominal arm
    arm = 1;
    tick(1);
    chk("arm_state1", int'(state), 1);
    chk("arm_en0", int'(en), 0);
    chk("arm_ready_lag", int'(ready), 1);
    tick(1);
    chk("arm_ready0", int'(ready), 0);
    tick(2);
    chk("arm_still_arming", int'(state), 1);
    chk("arm_en_still0", int'(en), 0);
    tick(1);
    chk("run_state", int'(state), 2);
    chk("run_en", int'(en), 1);

    // single-cycle overlap is filtered
    u = 1; x = 1;
    tick(1);
    u = 0; x = 0;
    tick(3);
    chk("st_short_ignored", int'(state), 2);

    // two-cycle overlap trips
    u = 1; x = 1;
    tick(2);
    u = 0; x = 0;
    chk("st_pre_state", int'(state), 2);
    chk("st_pre_en", int'(en), 1);
    tick(1);
    chk("st_fault_state", int'(state), 3);
    chk("st_fault_en", int'(en), 0);
    chk("st_fault_code", int'(code), 2);

    // clear rules
    arm = 0;
    tick(3);
    clr = 1;
    tick(1);
    clr = 0;
    chk("clr_early_ignored", int'(state), 3);
    tick(5);
    arm = 1; clr = 1;
    tick(1);
    chk("clr_with_arm_ignored", int'(state), 3);
    arm = 0;
    tick(1);
    chk("clr_accepted_state", int'(state), 0);
    chk("clr_accepted_code", int'(code), 0);
    clr = 0;

    // external fault, then a re-assert during hold restarts it
    fault_n = 0;
    tick(1);
    fault_n = 1;
    tick(2);
    chk("ext_state", int'(state), 3);
    chk("ext_code", int'(code), 1);
    tick(4);
    fault_n = 0;
    tick(1);
    fault_n = 1;
    tick(4);
    clr = 1;
    tick(1);
    chk("hold_restart_a", int'(state), 3);
    tick(5);
    chk("hold_restart_b", int'(state), 3);
    tick(1);
    chk("hold_restart_exit", int'(state), 0);
    clr = 0;

    // abort mid-arming
    arm = 1;
    tick(2);
    arm = 0;
    tick(1);
    chk("abort_state", int'(state), 0);
    chk("abort_en", int'(en), 0);

    // fault coincident with arm completion
    arm = 1;
    tick(2);
    fault_n = 0;
    tick(1);
    fault_n = 1;
    tick(1);
    chk("coinc_pre", int'(state), 1);
    tick(1);
    chk("coinc_state", int'(state), 3);
    chk("coinc_en", int'(en), 0);
    chk("coinc_code", int'(code), 1);
    arm = 0;
    tick(9);
    clr = 1;
    tick(1);
    chk("coinc_clear", int'(state), 0);
    clr = 0;

    // fault together with disarm
    arm = 1;
    tick(5);
    chk("dis_run", int'(state), 2);
    v = 1; y = 1;
    tick(2);
    v = 0; y = 0; disarm = 1;
    tick(1);
    chk("dis_fault_state", int'(state), 3);
    chk("dis_fault_code", int'(code), 2);
    disarm = 0; arm = 0;
    tick(9);
    clr = 1;
    tick(1);
    chk("dis_clear", int'(state), 0);
    clr = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) arm = ~arm;
      disarm  = ($urandom_range(31) == 0);
      fault_n = ($urandom_range(79) != 0);
      clr     = ($urandom_range(3) == 0);
      u = ($urandom_range(3) == 0); x = ($urandom_range(3) == 0);
      v = ($urandom_range(3) == 0); y = ($urandom_range(3) == 0);
      w = ($urandom_range(3) == 0); z = ($urandom_range(3) == 0);
      tick(1);
    end

    // asynchronous reset in RUN
    arm = 0; disarm = 0; fault_n = 1; clr = 0;
    u = 0; v = 0; w = 0; x = 0; y = 0; z = 0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    arm = 1;
    tick(5);
    chk("ar_run_state", int'(state), 2);
    chk("ar_run_en", int'(en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_en", int'(en), 0);
    chk("ar_async_state", int'(state), 0);
    @(negedge clk);
    arm = 0;
    rst_n = 1'b1;
    tick(1);
    chk("ar_post_state", int'(state), 0);
    chk("ar_post_code", int'(code), 0);
    chk("ar_post_ready", int'(ready), 1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_enable_ctrl.md
Name: gate_enable_ctrl

Overview:
Generates the EN_OUTPUT signal that qualifies the six PWM gate signals before they reach the inverter gate drivers. It sequences arming with a startup delay and monitors the same U/V/W (upper) and X/Y/Z (lower) gate signals for shoot-through on pairs U/X, V/Y and W/Z. It also latches external and shoot-through faults and forces the outputs off until an explicit, qualified clear. It sits between the PWM modulator/system controller and the output gate-qualification stage.

Parameters:
ARM_DELAY, 1000, cycles spent in ARMING before EN_OUTPUT asserts (>=1)
ST_FILTER, 2, consecutive cycles a pair must be both-high to flag shoot-through (>=1)
FAULT_HOLD, 100, minimum cycles in FAULT before a clear is accepted (>=1)
CNT_W, 16, counter width; must hold max(ARM_DELAY, FAULT_HOLD, ST_FILTER)

Ports:
CLK  in  1  system clock, single clock domain
RST_N  in  1  asynchronous active-low reset
ARM_REQ  in  1  level; 1 = request outputs enabled
DISARM  in  1  synchronous disable request, level, overrides ARM_REQ
FAULT_N_IN  in  1  external driver fault, active-low, asynchronous to CLK
FAULT_CLR  in  1  fault-clear request, sampled per cycle
U_IN, V_IN, W_IN, X_IN, Y_IN, Z_IN  in  1 each  PWM gate signals, CLK-synchronous
EN_OUTPUT  out  1  registered enable to the gate-qualification stage
STATE  out  2  0=IDLE 1=ARMING 2=RUN 3=FAULT
FAULT_CODE  out  2  sticky; bit0 external fault, bit1 shoot-through
READY  out  1  1 when in IDLE with no active fault condition

Behaviour:
- Reset (async, RST_N low): STATE=IDLE, EN_OUTPUT=0, FAULT_CODE=0, READY=0, all counters and synchronizer flops cleared. Synchronizer flops reset to the inactive level (1). EN_OUTPUT drops immediately on RST_N assertion, including mid-RUN.
- READY: registered; equals (STATE==IDLE && ext_fault==0) and updates one cycle after the condition changes.
- ext_fault = FAULT_N_IN after a 2-flop synchronizer, inverted. Latency is 2 edges to the internal signal.
- Shoot-through detection: one counter per pair, incremented while both signals are high and cleared otherwise. st_fault[p] pulses when the counter reaches ST_FILTER. The counter saturates there and holds until the pair deasserts.
- Fault detection (ext_fault or any st_fault) applies in every state and has highest priority. At the next edge: STATE=FAULT, EN_OUTPUT=0, the corresponding FAULT_CODE bits are OR-ed in, and the hold counter is cleared.
- IDLE: if ARM_REQ=1, DISARM=0 and no fault, go to ARMING with arm counter=0.
- ARMING:
  - Arm counter increments each cycle.
  - ARM_REQ=0 or DISARM=1 returns to IDLE.
  - When the counter reaches ARM_DELAY-1, go to RUN with EN_OUTPUT=1 on the same edge.
  - Net effect: ARM_REQ first sampled high at edge k gives EN_OUTPUT high after edge k+ARM_DELAY.
- RUN: EN_OUTPUT=1. ARM_REQ=0 or DISARM=1 returns to IDLE with EN_OUTPUT=0 at the next edge.
- FAULT: EN_OUTPUT=0.
  - Hold counter saturates at FAULT_HOLD.
  - A new fault while in FAULT ORs in code bits and restarts the hold counter.
  - Exit to IDLE only when all of these hold in the same cycle: hold counter==FAULT_HOLD, FAULT_CLR=1, ext_fault=0, no pair both-high, ARM_REQ=0.
  - On exit, FAULT_CODE is cleared.
  - FAULT_CLR outside that window is ignored, not remembered.
- Simultaneous events:
  - A fault in the same cycle as arm completion goes to FAULT; EN_OUTPUT never pulses.
  - A fault together with DISARM goes to FAULT.
  - FAULT_CLR together with a new fault stays in FAULT.
- No automatic re-arm: ARM_REQ must be low to leave FAULT and must rise again (be seen high in IDLE) to re-arm.

Decomposition:
- Package gate_ctrl_pkg holds:
  - the STATE encoding enum (IDLE/ARMING/RUN/FAULT)
  - FAULT_CODE bit indices (FLT_EXT=0, FLT_ST=1)
  - the 2-bit widths
- Sub-module pwm_shoot_detect (parameter ST_FILTER, CNT_W): inputs hi, lo; output st_fault. Instantiated three times.
- The synchronizer and FSM stay in the top module.

Test Plan:
- Arm nominal, ARM_DELAY=4: ARM_REQ high sampled at edge 10 -> STATE=1 after edge 10, EN_OUTPUT=1 after edge 14, READY=0 from edge 11.
- Shoot-through, ST_FILTER=2, RUN: U_IN=X_IN=1 for 1 cycle -> no fault. Both high 2 cycles -> FAULT, EN_OUTPUT=0 one edge after the 2nd cycle, FAULT_CODE=2'b10.
- External fault: FAULT_N_IN low in RUN -> EN_OUTPUT=0 and FAULT_CODE=2'b01 by the 3rd edge.
- Clear rules, FAULT_HOLD=8:
  - FAULT_CLR at hold count 3 -> ignored.
  - FAULT_CLR with ARM_REQ=1 after hold elapses -> ignored.
  - FAULT_CLR with ARM_REQ=0 after hold elapses -> IDLE and FAULT_CODE=0.
  - Fault re-asserted during hold -> hold counter restarts.
- Abort and priority: ARM_REQ drops mid-ARMING -> IDLE, EN_OUTPUT stays 0. Fault in the cycle arm counter==ARM_DELAY-1 -> FAULT, EN_OUTPUT never 1.
- Reset mid-RUN: RST_N low asynchronously -> EN_OUTPUT=0 without a clock edge. After release: STATE=0, FAULT_CODE=0.
